// File: rtl/instr_decoder_pkg.sv
// Shared decode definitions: opcode/funct constants, decoded-instruction struct,
// and the immediate-format classifier used by the immediate generator.
package instr_decoder_pkg;

   // Major opcodes (raw[6:0])
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] AMO      = 7'b0101111;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

   // funct3 for OP / OP_IMM, AMO width and SYSTEM privileged group
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_AMO_W   = 3'b010;
   localparam logic [2:0] F3_PRIV    = 3'b000;

   // funct7 groups
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // One-hot mnemonic flags (at most one set per decoded word)
   typedef struct packed {
      logic lui, auipc, jal, jalr;
      logic beq, bne, blt, bge, bltu, bgeu;
      logic lb, lh, lw, lbu, lhu;
      logic sb, sh, sw;
      logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
      logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
      logic fence, fencei, ecall, ebreak;
      logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
      logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
      logic lr, sc, amoswap, amoadd, amoxor, amoand, amoor;
      logic amomin, amomax, amominu, amomaxu;
      logic sret, mret, wfi, sfence_vma;
   } flags_t;

   typedef struct packed {
      flags_t      flags;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [11:0] csr;
      logic        writes_rd;
   } instructions_t;

   typedef enum logic [2:0] {
      FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_SH
   } imm_fmt_e;

   // Immediate format implied by the opcode (and funct3 for shifts / CSR-imm)
   function automatic imm_fmt_e imm_fmt(input logic [31:0] raw);
      imm_fmt_e fmt;
      fmt = FMT_NONE;
      case (raw[6:0])
         LOAD, JALR, MISC_MEM: fmt = FMT_I;
         OP_IMM:   fmt = (raw[13:12] == 2'b01) ? FMT_SH : FMT_I;
         STORE:    fmt = FMT_S;
         BRANCH:   fmt = FMT_B;
         LUI, AUIPC: fmt = FMT_U;
         JAL:      fmt = FMT_J;
         SYSTEM:   fmt = raw[14] ? FMT_Z : FMT_I;
         default:  fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/instr_decoder_imm_gen.sv
// Combinational immediate generator: raw word -> format-selected 32-bit imm.
module instr_decoder_imm_gen
   import instr_decoder_pkg::*;
(
   input  logic [31:0] raw,
   output logic [31:0] imm
);

   // Assemble the immediate for the format implied by the opcode
   always_comb begin
      imm = '0;
      case (imm_fmt(raw))
         FMT_I:  imm = {{20{raw[31]}}, raw[31:20]};
         FMT_S:  imm = {{20{raw[31]}}, raw[31:25], raw[11:7]};
         FMT_B:  imm = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
         FMT_U:  imm = {raw[31:12], 12'b0};
         FMT_J:  imm = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
         FMT_Z:  imm = {27'b0, raw[19:15]};
         FMT_SH: imm = {27'b0, raw[24:20]};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/instr_decoder.sv
// Registered RV32IMA + Zicsr + Zifencei + privileged decoder with an
// enabled/completed handshake; one decoded result per accepted request.
module instr_decoder
   import instr_decoder_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          enabled,
   input  logic [31:0]   pc,
   input  logic [31:0]   raw,
   output logic          completed,
   output instructions_t instr,
   output logic          is_illegal
);

   logic [6:0]    opcode, funct7;
   logic [2:0]    funct3;
   logic [31:0]   imm;
   flags_t        fl;
   logic          illegal, no_rd;
   logic          completed_d, completed_q;
   logic          illegal_d, illegal_q;
   instructions_t instr_d, instr_q;

   assign opcode = raw[6:0];
   assign funct3 = raw[14:12];
   assign funct7 = raw[31:25];

   instr_decoder_imm_gen u_imm_gen (
      .raw (raw),
      .imm (imm)
   );

   // Mnemonic flag decode and legality; no_rd marks ops whose rd is not written
   always_comb begin
      fl      = '0;
      illegal = 1'b0;
      no_rd   = 1'b0;
      case (opcode)
         LUI:   fl.lui   = 1'b1;
         AUIPC: fl.auipc = 1'b1;
         JAL:   fl.jal   = 1'b1;
         JALR:  if (funct3 == 3'b000) fl.jalr = 1'b1; else illegal = 1'b1;
         BRANCH: begin
            no_rd = 1'b1;
            case (funct3)
               3'b000: fl.beq  = 1'b1;
               3'b001: fl.bne  = 1'b1;
               3'b100: fl.blt  = 1'b1;
               3'b101: fl.bge  = 1'b1;
               3'b110: fl.bltu = 1'b1;
               3'b111: fl.bgeu = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         LOAD: begin
            case (funct3)
               3'b000: fl.lb  = 1'b1;
               3'b001: fl.lh  = 1'b1;
               3'b010: fl.lw  = 1'b1;
               3'b100: fl.lbu = 1'b1;
               3'b101: fl.lhu = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         STORE: begin
            no_rd = 1'b1;
            case (funct3)
               3'b000: fl.sb = 1'b1;
               3'b001: fl.sh = 1'b1;
               3'b010: fl.sw = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OP_IMM: begin
            case (funct3)
               F3_ADD_SUB: fl.addi  = 1'b1;
               F3_SLT:     fl.slti  = 1'b1;
               F3_SLTU:    fl.sltiu = 1'b1;
               F3_XOR:     fl.xori  = 1'b1;
               F3_OR:      fl.ori   = 1'b1;
               F3_AND:     fl.andi  = 1'b1;
               F3_SLL:     if (funct7 == F7_BASE) fl.slli = 1'b1; else illegal = 1'b1;
               F3_SR: begin
                  if (funct7 == F7_BASE)     fl.srli = 1'b1;
                  else if (funct7 == F7_ALT) fl.srai = 1'b1;
                  else                       illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         OP: begin
            case (funct7)
               F7_BASE: begin
                  case (funct3)
                     F3_ADD_SUB: fl.add    = 1'b1;
                     F3_SLL:     fl.sll    = 1'b1;
                     F3_SLT:     fl.slt    = 1'b1;
                     F3_SLTU:    fl.sltu   = 1'b1;
                     F3_XOR:     fl.xor_op = 1'b1;
                     F3_SR:      fl.srl    = 1'b1;
                     F3_OR:      fl.or_op  = 1'b1;
                     F3_AND:     fl.and_op = 1'b1;
                     default:    illegal   = 1'b1;
                  endcase
               end
               F7_ALT: begin
                  if (funct3 == F3_ADD_SUB) fl.sub = 1'b1;
                  else if (funct3 == F3_SR) fl.sra = 1'b1;
                  else                      illegal = 1'b1;
               end
               F7_MULDIV: begin
                  case (funct3)
                     3'b000: fl.mul    = 1'b1;
                     3'b001: fl.mulh   = 1'b1;
                     3'b010: fl.mulhsu = 1'b1;
                     3'b011: fl.mulhu  = 1'b1;
                     3'b100: fl.div    = 1'b1;
                     3'b101: fl.divu   = 1'b1;
                     3'b110: fl.rem    = 1'b1;
                     3'b111: fl.remu   = 1'b1;
                     default: illegal  = 1'b1;
                  endcase
               end
               default: illegal = 1'b1;
            endcase
         end
         MISC_MEM: begin
            no_rd = 1'b1;
            if (funct3 == 3'b000)      fl.fence  = 1'b1;
            else if (funct3 == 3'b001) fl.fencei = 1'b1;
            else                       illegal   = 1'b1;
         end
         AMO: begin
            if (funct3 != F3_AMO_W) illegal = 1'b1;
            else begin
               case (raw[31:27])
                  5'b00010: fl.lr      = 1'b1;
                  5'b00011: fl.sc      = 1'b1;
                  5'b00001: fl.amoswap = 1'b1;
                  5'b00000: fl.amoadd  = 1'b1;
                  5'b00100: fl.amoxor  = 1'b1;
                  5'b01100: fl.amoand  = 1'b1;
                  5'b01000: fl.amoor   = 1'b1;
                  5'b10000: fl.amomin  = 1'b1;
                  5'b10100: fl.amomax  = 1'b1;
                  5'b11000: fl.amominu = 1'b1;
                  5'b11100: fl.amomaxu = 1'b1;
                  default:  illegal    = 1'b1;
               endcase
            end
         end
         SYSTEM: begin
            case (funct3)
               F3_PRIV: begin
                  no_rd = 1'b1;
                  if (raw[31:20] == 12'h000)      fl.ecall  = 1'b1;
                  else if (raw[31:20] == 12'h001) fl.ebreak = 1'b1;
                  else if (raw[31:20] == 12'h102) fl.sret   = 1'b1;
                  else if (raw[31:20] == 12'h302) fl.mret   = 1'b1;
                  else if (raw[31:20] == 12'h105) fl.wfi    = 1'b1;
                  else if (funct7 == 7'b0001001)  fl.sfence_vma = 1'b1;
                  else                            illegal   = 1'b1;
               end
               3'b001: fl.csrrw  = 1'b1;
               3'b010: fl.csrrs  = 1'b1;
               3'b011: fl.csrrc  = 1'b1;
               3'b101: fl.csrrwi = 1'b1;
               3'b110: fl.csrrsi = 1'b1;
               3'b111: fl.csrrci = 1'b1;
               default: illegal  = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) fl = '0;
   end

   // Next-state: capture a new decode when enabled, otherwise hold the last one
   always_comb begin
      completed_d = enabled;
      instr_d     = instr_q;
      illegal_d   = illegal_q;
      if (enabled) begin
         instr_d.flags     = fl;
         instr_d.imm       = imm;
         instr_d.pc        = pc;
         instr_d.rs1       = raw[19:15];
         instr_d.rs2       = raw[24:20];
         instr_d.rd        = raw[11:7];
         instr_d.csr       = raw[31:20];
         instr_d.writes_rd = !illegal && !no_rd && (raw[11:7] != 5'd0);
         illegal_d         = illegal;
      end
   end

   // Output register with asynchronous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         completed_q <= 1'b0;
         illegal_q   <= 1'b0;
         instr_q     <= '0;
      end else begin
         completed_q <= completed_d;
         illegal_q   <= illegal_d;
         instr_q     <= instr_d;
      end
   end

   assign completed  = completed_q;
   assign instr      = instr_q;
   assign is_illegal = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: stimulus pushes hand-computed expected
// decodes, a negedge monitor pops and compares whenever completed is high.
module tb_instr_decoder;
   import instr_decoder_pkg::*;

   logic          clk = 1'b0;
   logic          rstn;
   logic          enabled;
   logic [31:0]   pc;
   logic [31:0]   raw;
   logic          completed;
   instructions_t instr;
   logic          is_illegal;

   typedef struct {
      string       name;
      flags_t      flags;
      logic [31:0] imm, mask, pc;
      logic [4:0]  rs1, rs2, rd;
      logic        wr, ill;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   instr_decoder dut (
      .clk        (clk),
      .rstn       (rstn),
      .enabled    (enabled),
      .pc         (pc),
      .raw        (raw),
      .completed  (completed),
      .instr      (instr),
      .is_illegal (is_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every completed cycle must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rstn && completed) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL spurious_completed: got completed=1 required no pending request");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (instr.flags !== e.flags || (instr.imm & e.mask) !== (e.imm & e.mask) ||
                instr.pc !== e.pc || instr.rs1 !== e.rs1 || instr.rs2 !== e.rs2 ||
                instr.rd !== e.rd || instr.writes_rd !== e.wr || is_illegal !== e.ill) begin
               n_fail++;
               $display("FAIL %s: got flags=%h imm=%h pc=%h rs1=%0d rs2=%0d rd=%0d wr=%b ill=%b required flags=%h imm=%h(mask %h) pc=%h rs1=%0d rs2=%0d rd=%0d wr=%b ill=%b",
                        e.name, instr.flags, instr.imm, instr.pc, instr.rs1, instr.rs2, instr.rd,
                        instr.writes_rd, is_illegal, e.flags, e.imm, e.mask, e.pc, e.rs1, e.rs2,
                        e.rd, e.wr, e.ill);
            end
         end
      end
   end

   task automatic issue(input string nm, input logic [31:0] r, input logic [31:0] p,
                        input flags_t f, input logic [31:0] im, input logic [31:0] mk,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic w, input logic il);
      exp_t e;
      e.name = nm; e.flags = f; e.imm = im; e.mask = mk; e.pc = p;
      e.rs1 = s1; e.rs2 = s2; e.rd = d; e.wr = w; e.ill = il;
      exp_q.push_back(e);
      enabled = 1'b1;
      raw     = r;
      pc      = p;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      enabled = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic ok, input logic [31:0] got,
                        input logic [31:0] req);
      n_vec++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   flags_t f;

   initial begin
      rstn = 1'b0; enabled = 1'b0; pc = '0; raw = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_completed", completed == 1'b0, {31'b0, completed}, 32'h0);
      check("reset_instr", instr == '0 && is_illegal == 1'b0, instr.imm | instr.pc, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // addi x1,x0,-1 single request, then hold
      f = '0; f.addi = 1'b1;
      issue("addi", 32'hFFF00093, 32'h100, f, 32'hFFFFFFFF, '1, 5'd0, 5'd31, 5'd1, 1'b1, 1'b0);
      idle(1);
      check("addi_completed_drop", completed == 1'b0, {31'b0, completed}, 32'h0);
      check("addi_hold", instr.flags.addi && instr.imm == 32'hFFFFFFFF && instr.pc == 32'h100,
            instr.imm, 32'hFFFFFFFF);

      // lui then beq back to back
      f = '0; f.lui = 1'b1;
      issue("lui", 32'h123452B7, 32'h104, f, 32'h12345000, '1, 5'd8, 5'd3, 5'd5, 1'b1, 1'b0);
      f = '0; f.beq = 1'b1;
      issue("beq", 32'hFE208EE3, 32'h108, f, 32'hFFFFFFFC, '1, 5'd1, 5'd2, 5'd29, 1'b0, 1'b0);
      check("b2b_completed", completed == 1'b1, {31'b0, completed}, 32'h1);
      idle(2);
      check("beq_hold", instr.flags.beq && instr.pc == 32'h108, instr.pc, 32'h108);

      // shift-immediate legality
      f = '0; f.srai = 1'b1;
      issue("srai", 32'h40525193, 32'h10C, f, 32'h5, 32'h1F, 5'd4, 5'd5, 5'd3, 1'b1, 1'b0);
      issue("srai_raw25", 32'h42525193, 32'h110, '0, 32'h0, 32'h0, 5'd4, 5'd5, 5'd3, 1'b0, 1'b1);
      issue("zero_word", 32'h00000000, 32'h114, '0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      f = '0; f.mret = 1'b1;
      issue("mret", 32'h30200073, 32'h118, f, 32'h0, 32'h0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0);
      f = '0; f.mul = 1'b1;
      issue("mul_rd0", 32'h02208033, 32'h11C, f, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
      f = '0; f.amoswap = 1'b1;
      issue("amoswap", 32'h0820A1AF, 32'h120, f, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      issue("amo_f3_011", 32'h0820B1AF, 32'h124, '0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      f = '0; f.sw = 1'b1;
      issue("sw", 32'h0020A423, 32'h128, f, 32'h8, '1, 5'd1, 5'd2, 5'd8, 1'b0, 1'b0);
      f = '0; f.jal = 1'b1;
      issue("jal", 32'h010000EF, 32'h200, f, 32'h10, '1, 5'd0, 5'd16, 5'd1, 1'b1, 1'b0);
      f = '0; f.csrrwi = 1'b1;
      issue("csrrwi", 32'h3052D373, 32'h204, f, 32'h5, '1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      idle(3);
      check("queue_drained", exp_q.size() == 0, exp_q.size(), 32'h0);

      // reset pulsed while a request is in flight
      enabled = 1'b1; raw = 32'h123452B7; pc = 32'h300;
      @(posedge clk);
      #1 enabled = 1'b0;
      #1 rstn = 1'b0;
      #1;
      check("rst_mid_completed", completed == 1'b0, {31'b0, completed}, 32'h0);
      check("rst_mid_instr", instr == '0 && is_illegal == 1'b0, instr.imm | instr.pc, 32'h0);
      #1 rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release_1", completed == 1'b0, {31'b0, completed}, 32'h0);
      @(posedge clk);
      #1;
      check("rst_release_2", completed == 1'b0 && instr == '0, {31'b0, completed}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
